// File: rtl/lcd_line_streamer.sv
// Renders one captured instruction (and optionally its PC) as LCD text and
// streams the frame one character per valid/ready handshake, line by line.
module lcd_line_streamer #(
    parameter int         LINE_CHARS = 16,
    parameter int         NUM_LINES  = 2,
    parameter logic [7:0] PAD_CHAR   = 8'h20,
    parameter int         PC_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] pc,
    input  logic            mode,
    output logic            char_valid,
    input  logic            char_ready,
    output logic [7:0]      char_data,
    output logic [1:0]      char_line,
    output logic [4:0]      char_col,
    output logic            frame_done,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    typedef enum logic [2:0] {C_NONE, C_REG, C_REG2, C_REG_IMM, C_IMM, C_DB} fmt_t;

    localparam logic [4:0] COL_MAX    = 5'(LINE_CHARS - 1);
    localparam logic [1:0] LINE_MAX   = 2'(NUM_LINES - 1);
    localparam bit         MULTI_LINE = (NUM_LINES > 1);

    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic            mode_q;
    logic [1:0]      line_q;
    logic [4:0]      col_q;
    logic            hs, last_char, pc_mode;
    logic [1:0]      inst_line;
    logic [7:0]      ch;
    logic [7:0]      itext [0:31];
    logic [7:0]      ptext [0:31];

    function automatic logic [7:0] hexc(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    // Mnemonics are left-justified and space-padded to four characters.
    function automatic logic [31:0] mnem(input logic [7:0] op);
        case (op)
            8'd0:  mnem = "nop ";  8'd1:  mnem = "mov ";  8'd2:  mnem = "lod ";  8'd3:  mnem = "sto ";
            8'd4:  mnem = "push";  8'd5:  mnem = "pop ";  8'd6:  mnem = "cmp ";  8'd7:  mnem = "inc ";
            8'd8:  mnem = "dec ";  8'd9:  mnem = "neg ";  8'd10: mnem = "add ";  8'd11: mnem = "addi";
            8'd12: mnem = "sub ";  8'd13: mnem = "subi";  8'd14: mnem = "mul ";  8'd15: mnem = "imul";
            8'd16: mnem = "div ";  8'd17: mnem = "idiv";  8'd18: mnem = "not ";  8'd19: mnem = "shl ";
            8'd20: mnem = "shli";  8'd21: mnem = "shr ";  8'd22: mnem = "shri";  8'd23: mnem = "sar ";
            8'd24: mnem = "sari";  8'd25: mnem = "and ";  8'd26: mnem = "test";  8'd27: mnem = "or  ";
            8'd28: mnem = "xor ";  8'd29: mnem = "call";  8'd30: mnem = "jmp ";  8'd31: mnem = "ret ";
            8'd32: mnem = "jz  ";  8'd33: mnem = "je  ";  8'd34: mnem = "jne ";  8'd35: mnem = "jnz ";
            8'd36: mnem = "ja  ";  8'd37: mnem = "jb  ";  8'd38: mnem = "jbe ";  8'd39: mnem = "jae ";
            8'd40: mnem = "jg  ";  8'd41: mnem = "jl  ";  8'd42: mnem = "jle ";  8'd43: mnem = "jge ";
            8'd44: mnem = "js  ";  8'd45: mnem = "jns ";  8'd46: mnem = "jc  ";  8'd47: mnem = "jnc ";
            8'd48: mnem = "jo  ";  8'd49: mnem = "jno ";
            default: mnem = "db  ";
        endcase
    endfunction

    function automatic fmt_t fmt_of(input logic [7:0] op);
        case (op)
            8'd0, 8'd31:                                    fmt_of = C_NONE;
            8'd4, 8'd5, 8'd7, 8'd8, 8'd9, 8'd18:            fmt_of = C_REG;
            8'd2, 8'd3, 8'd11, 8'd13, 8'd20, 8'd22, 8'd24:  fmt_of = C_REG_IMM;
            8'd29, 8'd30:                                   fmt_of = C_IMM;
            default: fmt_of = (op >= 8'd50) ? C_DB : ((op >= 8'd32) ? C_IMM : C_REG2);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        char_valid  = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so ready stays low for the whole reset window.
                instr_ready = rst_n;
                if (instr_valid) state_d = STREAM;
            end
            STREAM: begin
                char_valid = 1'b1;
                busy       = 1'b1;
                if (char_ready && last_char) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                busy       = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs        = char_valid && char_ready;
    assign last_char = (line_q == LINE_MAX) && (col_q == COL_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            mode_q  <= 1'b0;
            line_q  <= '0;
            col_q   <= '0;
        end else if (state_q == IDLE && instr_valid) begin
            instr_q <= instruction;
            pc_q    <= pc;
            mode_q  <= mode;
            line_q  <= '0;
            col_q   <= '0;
        end else if (hs) begin
            if (col_q == COL_MAX) begin
                col_q  <= '0;
                line_q <= last_char ? 2'd0 : line_q + 2'd1;
            end else begin
                col_q <= col_q + 5'd1;
            end
        end
    end

    always_comb begin : itext_build
        logic [31:0] mn;
        logic [4:0]  p;
        fmt_t        f;
        for (int i = 0; i < 32; i++) itext[5'(i)] = PAD_CHAR;
        mn = mnem(instr_q[31:24]);
        f  = fmt_of(instr_q[31:24]);
        p  = (mn[15:8] == " ") ? 5'd2 : ((mn[7:0] == " ") ? 5'd3 : 5'd4);
        for (int i = 0; i < 4; i++) if (5'(i) < p) itext[5'(i)] = mn[31-8*i -: 8];
        if (f == C_REG || f == C_REG2 || f == C_REG_IMM) begin
            itext[p]        = " ";
            itext[p + 5'd1] = "r";
            itext[p + 5'd2] = hexc(instr_q[19:16]);
        end
        case (f)
            C_REG2: begin
                itext[p + 5'd3] = " ";
                itext[p + 5'd4] = "r";
                itext[p + 5'd5] = hexc(instr_q[3:0]);
            end
            C_REG_IMM: begin
                itext[p + 5'd3] = " ";
                itext[p + 5'd4] = "0";
                itext[p + 5'd5] = "x";
                for (int k = 0; k < 4; k++) itext[p + 5'd6 + 5'(k)] = hexc(instr_q[15-4*k -: 4]);
            end
            C_IMM: begin
                itext[p]        = " ";
                itext[p + 5'd1] = "0";
                itext[p + 5'd2] = "x";
                for (int k = 0; k < 4; k++) itext[p + 5'd3 + 5'(k)] = hexc(instr_q[15-4*k -: 4]);
            end
            C_DB: begin
                itext[p]        = " ";
                itext[p + 5'd1] = "0";
                itext[p + 5'd2] = "x";
                for (int k = 0; k < 8; k++) itext[p + 5'd3 + 5'(k)] = hexc(instr_q[31-4*k -: 4]);
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 32; i++) ptext[5'(i)] = PAD_CHAR;
        ptext[0] = "P";
        ptext[1] = "C";
        ptext[2] = " ";
        ptext[3] = "0";
        ptext[4] = "x";
        for (int k = 0; k < PC_W/4; k++)
            if (k + 5 < 32) ptext[5'(k + 5)] = hexc(pc_q[PC_W-1-4*k -: 4]);
    end

    // A single-line display cannot hold a PC line, so mode falls back to 0.
    assign pc_mode   = mode_q && MULTI_LINE;
    assign inst_line = {1'b0, pc_mode};

    always_comb begin
        ch = PAD_CHAR;
        if (line_q == inst_line)            ch = itext[col_q];
        else if (pc_mode && line_q == 2'd0) ch = ptext[col_q];
    end

    assign char_data = char_valid ? ch : 8'h00;
    assign char_line = line_q;
    assign char_col  = col_q;

endmodule
